// File: rtl/obstacle_placer_pkg.sv
// Shared types for the obstacle placer: FSM states, grid cells and
// playfield bounds.
package obstacle_pkg;

  localparam int COORD_W = 4;
  localparam int X_MIN   = 1;
  localparam int X_MAX   = 14;
  localparam int Y_MIN   = 1;
  localparam int Y_MAX   = 10;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } obst_cell_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_QUERY,
    S_ADVANCE,
    S_COMMIT,
    S_FAIL
  } obst_state_t;

  function automatic logic in_grid(input obst_cell_t c);
    return (c.x >= coord_t'(X_MIN)) && (c.x <= coord_t'(X_MAX)) &&
           (c.y >= coord_t'(Y_MIN)) && (c.y <= coord_t'(Y_MAX));
  endfunction

endpackage

// File: rtl/obstacle_placer_table.sv
// Obstacle table: append-only write port, two parallel match ports
// sharing one compare array, and an indexed read port.
module obstacle_table
  import obstacle_pkg::*;
#(
  parameter  int MAX_OBST = 8,
  localparam int CW = $clog2(MAX_OBST + 1),
  localparam int IW = $clog2(MAX_OBST)
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          clear,
  input  logic          wr_en,
  input  obst_cell_t    wr_cell,
  input  obst_cell_t    m0_cell,
  output logic          m0_hit,
  input  obst_cell_t    m1_cell,
  output logic          m1_hit,
  input  logic [IW-1:0] rd_idx,
  output obst_cell_t    rd_cell,
  output logic          rd_valid,
  output logic [CW-1:0] count
);

  obst_cell_t    r_cells [MAX_OBST];
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_count <= '0;
      for (int i = 0; i < MAX_OBST; i++) r_cells[i] <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (wr_en && (r_count < CW'(MAX_OBST))) begin
      r_cells[r_count[IW-1:0]] <= wr_cell;
      r_count <= r_count + CW'(1);
    end
  end

  // Entries at or above count are stale and must never match.
  always_comb begin
    m0_hit = 1'b0;
    m1_hit = 1'b0;
    for (int i = 0; i < MAX_OBST; i++) begin
      if (CW'(i) < r_count) begin
        if (r_cells[i] == m0_cell) m0_hit = 1'b1;
        if (r_cells[i] == m1_cell) m1_hit = 1'b1;
      end
    end
  end

  assign rd_cell  = r_cells[rd_idx];
  assign rd_valid = CW'(rd_idx) < r_count;
  assign count    = r_count;

endmodule

// File: rtl/obstacle_placer.sv
// Obstacle placement sequencer; define OBST_MARGIN_EN to also keep
// obstacles out of the 3x3 neighbourhood of the snake head.
module obstacle_placer
  import obstacle_pkg::*;
#(
  parameter  int MAX_OBST  = 8,
  parameter  int MAX_TRIES = 16,
  localparam int CW = $clog2(MAX_OBST + 1),
  localparam int IW = $clog2(MAX_OBST),
  localparam int TW = $clog2(MAX_TRIES + 1)
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          clear,
  input  logic          place_req,
  input  coord_t        randX,
  input  coord_t        randY,
  output logic          obstacleFlag,
  output coord_t        query_x,
  output coord_t        query_y,
  output logic          query_valid,
  input  logic          query_hit,
  input  coord_t        head_x,
  input  coord_t        head_y,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [CW-1:0] obst_count,
  input  logic [IW-1:0] rd_idx,
  output coord_t        rd_x,
  output coord_t        rd_y,
  output logic          rd_valid,
  output logic          obst_hit
);

  obst_state_t   r_state;
  obst_state_t   w_next;
  logic [TW-1:0] r_tries;
  obst_cell_t    r_cand;
  logic          r_obst_hit;
  logic          w_commit;
  logic          w_cand_hit;
  logic          w_head_hit;
  logic          w_near;
  logic          w_reject;
  obst_cell_t    w_head;
  obst_cell_t    w_rd_cell;

  assign w_head = '{x: head_x, y: head_y};

  obstacle_table #(.MAX_OBST(MAX_OBST)) u_table (
    .clk      (clk),
    .nRst     (nRst),
    .clear    (clear),
    .wr_en    (w_commit),
    .wr_cell  (r_cand),
    .m0_cell  (r_cand),
    .m0_hit   (w_cand_hit),
    .m1_cell  (w_head),
    .m1_hit   (w_head_hit),
    .rd_idx   (rd_idx),
    .rd_cell  (w_rd_cell),
    .rd_valid (rd_valid),
    .count    (obst_count)
  );

`ifdef OBST_MARGIN_EN
  logic [COORD_W:0] w_dx;
  logic [COORD_W:0] w_dy;
  assign w_dx = (r_cand.x >= head_x) ? {1'b0, r_cand.x} - {1'b0, head_x}
                                     : {1'b0, head_x} - {1'b0, r_cand.x};
  assign w_dy = (r_cand.y >= head_y) ? {1'b0, r_cand.y} - {1'b0, head_y}
                                     : {1'b0, head_y} - {1'b0, r_cand.y};
  assign w_near = (w_dx <= (COORD_W+1)'(1)) && (w_dy <= (COORD_W+1)'(1));
`else
  assign w_near = (r_cand.x == head_x) && (r_cand.y == head_y);
`endif

  assign w_reject = !in_grid(r_cand) || query_hit || w_near || w_cand_hit;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state    <= S_IDLE;
      r_tries    <= '0;
      r_cand     <= '0;
      r_obst_hit <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_obst_hit <= clear ? 1'b0 : w_head_hit;
      if (r_state == S_SAMPLE) r_cand <= '{x: randX, y: randY};
      if (r_state == S_IDLE) r_tries <= '0;
      else if (r_state == S_QUERY && w_reject) r_tries <= r_tries + TW'(1);
    end
  end

  always_comb begin
    w_next       = r_state;
    w_commit     = 1'b0;
    done         = 1'b0;
    fail         = 1'b0;
    obstacleFlag = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (place_req)
          w_next = (obst_count == CW'(MAX_OBST)) ? S_FAIL : S_SAMPLE;
      end
      S_SAMPLE: w_next = S_QUERY;
      S_QUERY: begin
        if (!w_reject) w_next = S_COMMIT;
        else if (r_tries == TW'(MAX_TRIES - 1)) w_next = S_FAIL;
        else w_next = S_ADVANCE;
      end
      S_ADVANCE: begin
        obstacleFlag = 1'b1;
        w_next       = S_SAMPLE;
      end
      S_COMMIT: begin
        done         = 1'b1;
        obstacleFlag = 1'b1;
        w_commit     = 1'b1;
        w_next       = S_IDLE;
      end
      S_FAIL: begin
        fail   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Clear wins over everything, including a same-cycle request.
    if (clear) begin
      w_next       = S_IDLE;
      w_commit     = 1'b0;
      done         = 1'b0;
      fail         = 1'b0;
      obstacleFlag = 1'b0;
    end
  end

  assign query_x     = r_cand.x;
  assign query_y     = r_cand.y;
  assign query_valid = (r_state == S_QUERY);
  assign busy        = (r_state != S_IDLE);
  assign rd_x        = w_rd_cell.x;
  assign rd_y        = w_rd_cell.y;
  assign obst_hit    = r_obst_hit;

endmodule

// File: tb/tb_obstacle_placer.sv
// Self-checking bench for obstacle_placer: vector table of placements
// plus hand sequences for reject, fail, clear and reset corners.
module tb_obstacle_placer;
  import obstacle_pkg::*;

  logic       clk = 1'b0;
  logic       nRst = 1'b0;
  logic       clear = 1'b0;
  logic       place_req = 1'b0;
  coord_t     randX = '0;
  coord_t     randY = '0;
  logic       obstacleFlag;
  coord_t     query_x;
  coord_t     query_y;
  logic       query_valid;
  logic       query_hit;
  coord_t     head_x = 4'd5;
  coord_t     head_y = 4'd5;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] obst_count;
  logic [2:0] rd_idx = '0;
  coord_t     rd_x;
  coord_t     rd_y;
  logic       rd_valid;
  logic       obst_hit;

  obstacle_placer dut (
    .clk          (clk),
    .nRst         (nRst),
    .clear        (clear),
    .place_req    (place_req),
    .randX        (randX),
    .randY        (randY),
    .obstacleFlag (obstacleFlag),
    .query_x      (query_x),
    .query_y      (query_y),
    .query_valid  (query_valid),
    .query_hit    (query_hit),
    .head_x       (head_x),
    .head_y       (head_y),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .obst_count   (obst_count),
    .rd_idx       (rd_idx),
    .rd_x         (rd_x),
    .rd_y         (rd_y),
    .rd_valid     (rd_valid),
    .obst_hit     (obst_hit)
  );

  always #5 clk = ~clk;

  // Snake/apple occupancy model.
  logic       occ_all = 1'b0;
  logic       occ_en = 1'b0;
  obst_cell_t occ_cell = '0;
  assign query_hit = query_valid &&
    (occ_all || (occ_en && query_x == occ_cell.x && query_y == occ_cell.y));

  // Generator model: steps on each obstacleFlag pulse.
  obst_cell_t gen_q[$];
  always @(negedge clk)
    if (obstacleFlag && gen_q.size() > 0) {randX, randY} = gen_q.pop_front();

  typedef struct {
    bit ok;
    int lat;
    int x;
    int y;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    obst_cell_t c0;
    obst_cell_t c1;
    bit         use_c1;
    int         lat;
    int         cnt;
  } vec_t;
  vec_t vt[6];

  int n_chk = 0;
  int n_fail = 0;
  int flag_cnt;
  int qv_cnt;
  int ev;

  function automatic obst_cell_t mk(input int x, input int y);
    obst_cell_t c;
    c.x = coord_t'(x);
    c.y = coord_t'(y);
    return c;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Call just after a negedge; returns just after a negedge.
  task automatic place(input string name, input obst_cell_t c0,
                       input obst_cell_t c1, input bit use_c1,
                       input bit ok, input int lat, input int ex,
                       input int ey);
    exp_t e;
    bit   seen;
    bit   got_ok;
    bit   flag_at;
    int   got_lat;
    gen_q.delete();
    if (use_c1) gen_q.push_back(c1);
    {randX, randY} = c0;
    e.ok = ok; e.lat = lat; e.x = ex; e.y = ey;
    sb.push_back(e);
    flag_cnt = 0; qv_cnt = 0; seen = 0;
    got_ok = 0; got_lat = 0; flag_at = 0;
    place_req = 1'b1;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(posedge clk);
      #1 place_req = 1'b0;
      @(negedge clk);
      if (obstacleFlag) flag_cnt++;
      if (query_valid) qv_cnt++;
      if (done || fail) begin
        seen = 1; got_ok = done; got_lat = k; flag_at = obstacleFlag;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s: no done/fail within 200 cycles", name);
    end else begin
      chk({name, " done"}, int'(got_ok), int'(e.ok));
      chk({name, " latency"}, got_lat, e.lat);
      if (e.ok) chk({name, " flag@commit"}, int'(flag_at), 1);
      @(posedge clk);
      #1;
      chk({name, " busy after"}, int'(busy), 0);
      if (e.ok) begin
        rd_idx = 3'(obst_count - 4'd1);
        #1;
        chk({name, " rd_x"}, int'(rd_x), e.x);
        chk({name, " rd_y"}, int'(rd_y), e.y);
        chk({name, " rd_valid"}, int'(rd_valid), 1);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vt[0] = '{mk(0, 5),  mk(2, 2),   1'b1, 6, 3};
    vt[1] = '{mk(15, 1), mk(3, 10),  1'b1, 6, 4};
    vt[2] = '{mk(8, 2),  mk(1, 1),   1'b1, 6, 5};
    vt[3] = '{mk(5, 5),  mk(14, 10), 1'b1, 6, 6};
    vt[4] = '{mk(6, 11), mk(7, 7),   1'b1, 6, 7};
    vt[5] = '{mk(10, 1), mk(0, 0),   1'b0, 3, 8};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst fail", int'(fail), 0);
    chk("rst flag", int'(obstacleFlag), 0);
    chk("rst query_valid", int'(query_valid), 0);
    chk("rst query_x", int'(query_x), 0);
    chk("rst count", int'(obst_count), 0);
    chk("rst rd_valid", int'(rd_valid), 0);
    chk("rst obst_hit", int'(obst_hit), 0);
    nRst = 1'b1;
    @(negedge clk);

    // Clean placement
    place("t1", mk(8, 2), mk(0, 0), 1'b0, 1'b1, 3, 8, 2);
    chk("t1 count", int'(obst_count), 1);
    chk("t1 flags", flag_cnt, 1);

    // One reject on occupancy, then commit
    occ_en = 1'b1; occ_cell = mk(4, 4);
    place("t2", mk(4, 4), mk(9, 3), 1'b1, 1'b1, 6, 9, 3);
    occ_en = 1'b0;
    chk("t2 count", int'(obst_count), 2);
    chk("t2 flags", flag_cnt, 2);
    chk("t2 queries", qv_cnt, 2);

    // Tries exhausted
    occ_all = 1'b1;
    place("t3", mk(3, 3), mk(0, 0), 1'b0, 1'b0, 48, 0, 0);
    occ_all = 1'b0;
    chk("t3 queries", qv_cnt, 16);
    chk("t3 flags", flag_cnt, 15);
    chk("t3 count", int'(obst_count), 2);

    // Table-driven fill with every reject reason
    foreach (vt[i]) begin
      obst_cell_t c;
      c = vt[i].use_c1 ? vt[i].c1 : vt[i].c0;
      place($sformatf("vec%0d", i), vt[i].c0, vt[i].c1, vt[i].use_c1,
            1'b1, vt[i].lat, int'(c.x), int'(c.y));
      chk($sformatf("vec%0d count", i), int'(obst_count), vt[i].cnt);
    end

    // Full table
    place("t4", mk(12, 8), mk(0, 0), 1'b0, 1'b0, 1, 0, 0);
    chk("t4 flags", flag_cnt, 0);
    chk("t4 queries", qv_cnt, 0);
    chk("t4 count", int'(obst_count), 8);

    // Head collision flag
    chk("t5 no hit", int'(obst_hit), 0);
    {head_x, head_y} = mk(8, 2);
    @(negedge clk);
    chk("t5 hit first", int'(obst_hit), 1);
    {head_x, head_y} = mk(10, 1);
    @(negedge clk);
    chk("t5 hit last", int'(obst_hit), 1);
    {head_x, head_y} = mk(3, 3);
    @(negedge clk);
    chk("t5 miss", int'(obst_hit), 0);
    {head_x, head_y} = mk(8, 2);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t5 clear hit", int'(obst_hit), 0);
    chk("t5 clear count", int'(obst_count), 0);
    @(negedge clk);
    chk("t5 stale hit", int'(obst_hit), 0);
    rd_idx = 3'd0;
    #1 chk("t5 rd_valid", int'(rd_valid), 0);

    // Head margin
    {head_x, head_y} = mk(7, 2);
`ifdef OBST_MARGIN_EN
    place("t6", mk(8, 2), mk(12, 5), 1'b1, 1'b1, 6, 12, 5);
`else
    place("t6", mk(8, 2), mk(12, 5), 1'b1, 1'b1, 3, 8, 2);
`endif
    chk("t6 count", int'(obst_count), 1);
    {head_x, head_y} = mk(5, 5);

    // Clear during COMMIT
    {randX, randY} = mk(3, 3);
    place_req = 1'b1;
    @(posedge clk);
    #1 place_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 clear = 1'b1;
    @(negedge clk);
    chk("clr done", int'(done), 0);
    chk("clr flag", int'(obstacleFlag), 0);
    @(posedge clk);
    #1 clear = 1'b0;
    chk("clr count", int'(obst_count), 0);
    chk("clr busy", int'(busy), 0);

    // Request coinciding with clear is dropped
    @(negedge clk);
    clear = 1'b1; place_req = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0; place_req = 1'b0;
    chk("clr+req busy", int'(busy), 0);

    // Reset mid-request
    @(negedge clk);
    {randX, randY} = mk(4, 4);
    place_req = 1'b1;
    @(posedge clk);
    #1 place_req = 1'b0;
    chk("rstmid busy before", int'(busy), 1);
    nRst = 1'b0;
    #1;
    chk("rstmid busy", int'(busy), 0);
    @(negedge clk);
    nRst = 1'b1;
    ev = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || fail) ev++;
    end
    chk("rstmid no pulse", ev, 0);
    chk("rstmid count", int'(obst_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
